mem_access_sequencer: RTL and testbench

Sequences a single load or store between the control unit and the byte-addressed RAM in the memory path. It accepts one SPARC load/store request at a time and latches the address, store data and op3. It checks alignment and op3 legality, then drives RAM_enable/RAM_OpCode until the RAM returns MFC. It returns the captured load data with a one-cycle done pulse, or a one-cycle trap pulse carrying a trap type for the TBR path.

---
 rtl/mem_access_sequencer.sv | 104 ++++++++++
 tb/tb_mem_access_sequencer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/mem_access_sequencer.sv
// rtl/mem_access_sequencer.sv - single SPARC load/store sequencer between control unit and byte-addressed RAM
module mem_access_sequencer #(
    parameter int unsigned MFC_TIMEOUT = 15
) (
    input  logic        Clk,
    input  logic        RESET,
    input  logic        req,
    input  logic [5:0]  op3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        MFC,
    input  logic [31:0] rdata_in,
    output logic        busy,
    output logic        done,
    output logic        trap,
    output logic [2:0]  tt,
    output logic        RAM_enable,
    output logic [5:0]  RAM_OpCode,
    output logic [31:0] RAM_addr,
    output logic [31:0] RAM_wdata,
    output logic [31:0] rdata
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE, TRAP} state_t;

    localparam logic [7:0] LAST_CNT = 8'(MFC_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q;
    logic        hold_q;
    logic        illegal, misaligned, timeout;

    always_comb begin
        illegal    = 1'b0;
        misaligned = 1'b0;
        case (op3)
            6'b000000, 6'b000100:             misaligned = (addr[1:0] != 2'b00);
            6'b000001, 6'b000101, 6'b001001:  misaligned = 1'b0;
            6'b000010, 6'b000110, 6'b001010:  misaligned = addr[0];
            default:                          illegal    = 1'b1;
        endcase
    end

    assign timeout = (cnt_q == LAST_CNT);

    always_ff @(posedge Clk or negedge RESET) begin
        if (!RESET) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (req) state_d = (illegal || misaligned) ? TRAP : WAIT;
            WAIT: begin
                if (MFC)          state_d = DONE;
                else if (timeout) state_d = TRAP;
            end
            DONE: state_d = IDLE;
            TRAP: state_d = hold_q ? TRAP : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request-check traps spend one extra cycle in TRAP (hold_q) so the pulse lands after E1.
    always_ff @(posedge Clk or negedge RESET) begin
        if (!RESET) begin
            cnt_q      <= '0;
            hold_q     <= 1'b0;
            tt         <= '0;
            rdata      <= '0;
            RAM_OpCode <= '0;
            RAM_addr   <= '0;
            RAM_wdata  <= '0;
        end else begin
            case (state_q)
                IDLE: if (req) begin
                    RAM_OpCode <= op3;
                    RAM_addr   <= addr;
                    RAM_wdata  <= wdata;
                    cnt_q      <= '0;
                    hold_q     <= illegal || misaligned;
                    tt         <= illegal ? 3'd3 : (misaligned ? 3'd1 : 3'd0);
                end
                WAIT: begin
                    if (MFC) begin
                        if (!RAM_OpCode[2]) rdata <= rdata_in;
                    end else begin
                        if (cnt_q != 8'hff) cnt_q <= cnt_q + 8'd1;
                        if (timeout)        tt    <= 3'd2;
                    end
                end
                TRAP: hold_q <= 1'b0;
                default: ;
            endcase
        end
    end

    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign trap       = (state_q == TRAP) && !hold_q;
    assign RAM_enable = (state_q == WAIT);

endmodule

// File: tb/tb_mem_access_sequencer.sv
// tb/tb_mem_access_sequencer.sv - directed self-checking bench for mem_access_sequencer
module tb_mem_access_sequencer;

    logic        Clk = 1'b0;
    logic        RESET;
    logic        req;
    logic [5:0]  op3;
    logic [31:0] addr, wdata, rdata_in;
    logic        MFC;
    logic        busy, done, trap, RAM_enable;
    logic [2:0]  tt;
    logic [5:0]  RAM_OpCode;
    logic [31:0] RAM_addr, RAM_wdata, rdata;

    int n_checks = 0;
    int n_errors = 0;
    int en_n, done_n, trap_n, pulse_j, idle_j, lat_bad;

    mem_access_sequencer #(.MFC_TIMEOUT(15)) dut (
        .Clk(Clk), .RESET(RESET), .req(req), .op3(op3), .addr(addr), .wdata(wdata),
        .MFC(MFC), .rdata_in(rdata_in), .busy(busy), .done(done), .trap(trap), .tt(tt),
        .RAM_enable(RAM_enable), .RAM_OpCode(RAM_OpCode), .RAM_addr(RAM_addr),
        .RAM_wdata(RAM_wdata), .rdata(rdata)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one access; MFC is sampled high at WAIT edge k (k=0: never). Sample j follows edge E(j-1).
    task automatic access(input logic [5:0] o, input logic [31:0] a, input logic [31:0] w,
                          input int k, input logic [31:0] rd);
        req = 1'b1; op3 = o; addr = a; wdata = w; rdata_in = rd; MFC = 1'b0;
        en_n = 0; done_n = 0; trap_n = 0; pulse_j = 0; idle_j = 0; lat_bad = 0;
        tick();
        for (int j = 1; j <= 40; j++) begin
            if (RAM_enable) begin
                en_n++;
                if (RAM_addr !== a || RAM_wdata !== w || RAM_OpCode !== o) lat_bad++;
            end
            if (done) done_n++;
            if (trap) trap_n++;
            if ((done || trap) && pulse_j == 0) pulse_j = j;
            if (done || trap) req = 1'b0;
            if (!busy) begin
                idle_j = j;
                break;
            end
            MFC = (j == k);
            tick();
        end
        req = 1'b0;
        MFC = 1'b0;
    endtask

    initial begin
        RESET = 1'b0; req = 1'b0; op3 = '0; addr = '0; wdata = '0; rdata_in = 32'hffff_ffff; MFC = 1'b1;
        tick(); tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_trap", trap, 0);
        check("rst_en", RAM_enable, 0);
        check("rst_tt", tt, 0);
        check("rst_rdata", rdata, 0);
        check("rst_opcode", RAM_OpCode, 0);
        check("rst_addr", RAM_addr, 0);
        check("rst_wdata", RAM_wdata, 0);
        RESET = 1'b1; MFC = 1'b0;
        tick();

        // LD word, MFC on 2nd WAIT edge
        access(6'b000000, 32'd32, 32'd0, 2, 32'd9);
        check("ld_rdata", rdata, 9);
        check("ld_done_n", done_n, 1);
        check("ld_trap_n", trap_n, 0);
        check("ld_en_n", en_n, 2);
        check("ld_lat", pulse_j, 3);

        // ST word, MFC after 3 WAIT edges; rdata must keep 9
        access(6'b000100, 32'd32, 32'd9, 3, 32'hdead_beef);
        check("st_en_n", en_n, 3);
        check("st_latch", lat_bad, 0);
        check("st_done_n", done_n, 1);
        check("st_rdata", rdata, 9);
        check("st_idle_j", idle_j, 5);

        // misaligned halfword
        access(6'b000010, 32'd33, 32'd0, 1, 32'd0);
        check("mis_en_n", en_n, 0);
        check("mis_trap_n", trap_n, 1);
        check("mis_trap_j", pulse_j, 2);
        check("mis_tt", tt, 1);
        check("mis_done_n", done_n, 0);

        // signed byte at odd address, legal
        access(6'b001001, 32'd35, 32'd0, 1, 32'hffff_ff85);
        check("ldsb_trap_n", trap_n, 0);
        check("ldsb_tt", tt, 0);
        check("ldsb_rdata", rdata, 32'hffff_ff85);
        check("ldsb_lat", pulse_j, 2);

        // illegal op3
        access(6'b000011, 32'd0, 32'd0, 1, 32'd0);
        check("ill_tt", tt, 3);
        check("ill_trap_n", trap_n, 1);
        check("ill_en_n", en_n, 0);

        // MFC exactly at timeout edge wins
        access(6'b000001, 32'd7, 32'd0, 15, 32'h0000_00a5);
        check("edge_done_n", done_n, 1);
        check("edge_trap_n", trap_n, 0);
        check("edge_en_n", en_n, 15);
        check("edge_rdata", rdata, 32'ha5);

        // timeout
        access(6'b000000, 32'd12, 32'd0, 0, 32'd0);
        check("to_en_n", en_n, 15);
        check("to_trap_n", trap_n, 1);
        check("to_trap_j", pulse_j, 16);
        check("to_tt", tt, 2);
        check("to_done_n", done_n, 0);

        // async reset mid-WAIT
        req = 1'b1; op3 = 6'b000000; addr = 32'd16; wdata = 32'd0; MFC = 1'b0;
        tick(); tick();
        check("mid_en_before", RAM_enable, 1);
        RESET = 1'b0;
        #1;
        check("mid_en_after", RAM_enable, 0);
        check("mid_busy_after", busy, 0);
        check("mid_done", done, 0);
        check("mid_trap", trap, 0);
        req = 1'b0;
        #1 RESET = 1'b1;
        tick();
        access(6'b000110, 32'd2, 32'h1234, 1, 32'd0);
        check("post_rst_done_n", done_n, 1);
        check("post_rst_trap_n", trap_n, 0);

        // leave tt=2, then back-to-back with req held across done
        access(6'b000000, 32'd0, 32'd0, 0, 32'd0);
        check("b2b_pre_tt", tt, 2);
        req = 1'b1; op3 = 6'b000000; addr = 32'd4; wdata = 32'd0; rdata_in = 32'h11; MFC = 1'b0;
        tick();
        check("b2b_a_en", RAM_enable, 1);
        check("b2b_a_tt", tt, 0);
        MFC = 1'b1;
        tick();
        check("b2b_a_done", done, 1);
        check("b2b_a_rdata", rdata, 32'h11);
        MFC = 1'b0; op3 = 6'b000001; addr = 32'd8; rdata_in = 32'h22;
        tick();
        check("b2b_gap_busy", busy, 0);
        tick();
        check("b2b_b_en", RAM_enable, 1);
        check("b2b_b_addr", RAM_addr, 8);
        check("b2b_b_op", RAM_OpCode, 6'b000001);
        req = 1'b0; MFC = 1'b1;
        tick();
        MFC = 1'b0;
        check("b2b_b_done", done, 1);
        check("b2b_b_rdata", rdata, 32'h22);
        tick();
        check("b2b_end_busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
